// File: rtl/tt_pkg.sv
// -----------------------------------------------------------------------------
// tt_pkg
// Shared definitions for the truth-table sweeper:
//   tt_state_e      - sweep FSM states (IDLE, SETTLE, SAMPLE, DONE)
//   TT_CNT_W        - width of the settle counter (8 bits, SETTLE_CYCLES 1..255)
//   TT_N_IN_DEFAULT - default stimulus vector width
//   tt_table_w()    - truth table width for a given input width (2^n_in)
// -----------------------------------------------------------------------------
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } tt_state_e;

    localparam int unsigned TT_CNT_W        = 8;
    localparam int unsigned TT_N_IN_DEFAULT = 4;

    function automatic int unsigned tt_table_w(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage : tt_pkg

// File: rtl/tt_settle_timer.sv
// -----------------------------------------------------------------------------
// tt_settle_timer
// Load/count/expire counter that times how long a stimulus vector is held
// before the function output is sampled.
//
// Parameters:
//   SETTLE_CYCLES - clocks per vector before expiry, legal range 1..255
// Ports:
//   i_clk    in  1  rising-edge clock
//   i_rst    in  1  synchronous active-high reset, clears the count
//   i_load   in  1  restart the count from zero (on entry to SETTLE)
//   i_en     in  1  count enable (high while in SETTLE)
//   o_expire out 1  count has reached SETTLE_CYCLES-1 while enabled
// -----------------------------------------------------------------------------
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("tt_settle_timer: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [TT_CNT_W-1:0] LAST_CNT = TT_CNT_W'(SETTLE_CYCLES - 1);

    logic [TT_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == LAST_CNT);

endmodule : tt_settle_timer

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Steps a stimulus vector through all 2^N_IN combinations, holds each one for
// SETTLE_CYCLES clocks, samples the function output and assembles the complete
// truth table into one register.
//
// Optional feature (macro TT_GOLDEN_CHECK_EN): compare the finished table with
// EXPECTED and flag a difference on o_mismatch. Without the macro o_mismatch
// is tied low and EXPECTED is ignored.
//
// Parameters:
//   N_IN          - stimulus vector width (table width TABLE_W = 2^N_IN)
//   SETTLE_CYCLES - clocks each vector is held before sampling, 1..255
//   EXPECTED      - golden truth table (golden-check build only)
// Ports:
//   i_clk      in  1        rising-edge clock
//   i_rst      in  1        synchronous active-high reset
//   i_start    in  1        request a sweep, accepted only in IDLE
//   i_f_in     in  1        output of the function under sweep
//   o_abcd     out N_IN     stimulus vector, MSB = a, LSB = d
//   o_busy     out 1        high from the accepting edge until DONE
//   o_done     out 1        one-cycle pulse when the table is complete
//   o_table    out TABLE_W  bit i = f sampled while abcd == i
//   o_mismatch out 1        finished table differs from EXPECTED
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned                        N_IN          = TT_N_IN_DEFAULT,
    parameter int unsigned                        SETTLE_CYCLES = 1,
    parameter logic [tt_table_w(N_IN)-1:0]        EXPECTED      = '0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic                        i_f_in,
    output logic [N_IN-1:0]             o_abcd,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [tt_table_w(N_IN)-1:0] o_table,
    output logic                        o_mismatch
);

    localparam int unsigned     TABLE_W  = tt_table_w(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    tt_state_e          r_state;
    logic [N_IN-1:0]    r_idx;
    logic [N_IN-1:0]    r_abcd;
    logic [TABLE_W-1:0] r_table;
    logic               r_busy;
    logic               r_done;

    logic w_last;
    logic w_timer_load;
    logic w_timer_en;
    logic w_expire;

    assign w_last       = (r_idx == LAST_IDX);
    // Timer restarts whenever SETTLE is entered: at start acceptance and on
    // every SAMPLE exit that is not the final one.
    assign w_timer_load = ((r_state == IDLE) && i_start) ||
                          ((r_state == SAMPLE) && !w_last);
    assign w_timer_en   = (r_state == SETTLE);

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_timer_load),
        .i_en     (w_timer_en),
        .o_expire (w_expire)
    );

`ifdef TT_GOLDEN_CHECK_EN
    logic r_mismatch;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_abcd  <= '0;
            r_table <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef TT_GOLDEN_CHECK_EN
            r_mismatch <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= SETTLE;
                        r_table <= '0;
                        r_idx   <= '0;
                        r_abcd  <= '0;
                        r_busy  <= 1'b1;
`ifdef TT_GOLDEN_CHECK_EN
                        r_mismatch <= 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    if (w_expire) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_table[r_idx] <= i_f_in;
                    // The last index is not incremented, so the vector never wraps.
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_abcd  <= r_idx + 1'b1;
                        r_state <= SETTLE;
                    end
                end
                DONE: begin
                    r_abcd  <= '0;
                    r_state <= IDLE;
`ifdef TT_GOLDEN_CHECK_EN
                    // r_table holds the final table during the DONE cycle.
                    r_mismatch <= (r_table != EXPECTED);
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_abcd  = r_abcd;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_table = r_table;

`ifdef TT_GOLDEN_CHECK_EN
    assign o_mismatch = r_mismatch;
`else
    logic w_unused_expected;
    assign w_unused_expected = ^EXPECTED;
    assign o_mismatch        = 1'b0;
`endif

endmodule : truth_table_sweeper
